// File: rtl/fnd_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display.
// Shows a 16-bit hex value; a new value takes effect only at a frame boundary.
module fnd_scan_ctrl #(
  parameter int P_SCAN_DIV = 100000,
  parameter bit P_BLANK_LZ = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  input  logic        i_load,
  input  logic        i_enable,
  output logic [1:0]  o_digit_sel,
  output logic [7:0]  o_seg,
  output logic        o_pending,
  output logic        o_frame_tick
);

  localparam int PW = (P_SCAN_DIV > 2) ? $clog2(P_SCAN_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(P_SCAN_DIV - 1);
  localparam logic [1:0] IDX_LAST = 2'd3;

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    dp_q, dp_d;
  logic [15:0]   pend_val_q, pend_val_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          pending_q, pending_d;
  logic          frame_tick_q, frame_tick_d;
  logic [7:0]    seg_q, seg_d;

  logic          tick;
  logic          wrap;
  logic [3:0]    nib;
  logic          blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  always_comb begin
    tick         = (prescaler_q == PS_LAST);
    wrap         = tick && (idx_q == IDX_LAST);
    prescaler_d  = tick ? '0 : prescaler_q + PW'(1);
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    disp_d       = disp_q;
    dp_d         = dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pending_d    = pending_q;
    frame_tick_d = wrap;

    // A load on the wrap edge itself bypasses the buffer and wins over it.
    if (wrap) begin
      if (i_load) begin
        disp_d = i_value;
        dp_d   = i_dp;
      end else if (pending_q) begin
        disp_d = pend_val_q;
        dp_d   = pend_dp_q;
      end
      pending_d = 1'b0;
    end else if (i_load) begin
      pend_val_d = i_value;
      pend_dp_d  = i_dp;
      pending_d  = 1'b1;
    end

    // Segments are derived from next-state values so they track o_digit_sel exactly.
    case (idx_d)
      2'd0: begin nib = disp_d[3:0];   blank = 1'b0;                 end
      2'd1: begin nib = disp_d[7:4];   blank = (disp_d[15:4] == '0);  end
      2'd2: begin nib = disp_d[11:8];  blank = (disp_d[15:8] == '0);  end
      default: begin nib = disp_d[15:12]; blank = (disp_d[15:12] == '0); end
    endcase
    blank = blank && P_BLANK_LZ;

    seg_d = i_enable ? {~dp_d[idx_d], (blank ? 7'h7F : hex_to_seg(nib))} : 8'hFF;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prescaler_q  <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      dp_q         <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      seg_q        <= 8'hFF;
    end else begin
      prescaler_q  <= prescaler_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      dp_q         <= dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
      seg_q        <= seg_d;
    end
  end

  assign o_digit_sel  = idx_q;
  assign o_seg        = seg_q;
  assign o_pending    = pending_q;
  assign o_frame_tick = frame_tick_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: two instances (blanking on/off) checked against a
// cycle-count based reference model, table-driven frames and hand-written corner cases.
module tb_fnd_scan_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;
  localparam logic [7:0] HEX_TBL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [31:0] lz;   // {digit3,digit2,digit1,digit0} with blanking
    logic [31:0] all;  // same without blanking
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, load, enable;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [1:0]  sel_lz, sel_all;
  logic [7:0]  seg_lz, seg_all;
  logic        pend_lz, pend_all, ft_lz, ft_all;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_valid = 1'b0;
  int          m_cyc;
  bit          m_wrap;
  logic [15:0] m_disp, m_pv;
  logic [3:0]  m_dp, m_pdp;
  bit          m_pend, m_ft;
  logic [1:0]  m_sel;
  logic [7:0]  m_seg_lz, m_seg_all;

  logic [7:0]  got_lz [4];
  logic [7:0]  got_all [4];
  vec_t        vecs [6];

  always #5 clk = ~clk;

  fnd_scan_ctrl #(.P_SCAN_DIV(DIV), .P_BLANK_LZ(1'b1)) dut_lz (
    .i_clk(clk), .i_reset(reset), .i_value(value), .i_dp(dp), .i_load(load),
    .i_enable(enable), .o_digit_sel(sel_lz), .o_seg(seg_lz),
    .o_pending(pend_lz), .o_frame_tick(ft_lz));

  fnd_scan_ctrl #(.P_SCAN_DIV(DIV), .P_BLANK_LZ(1'b0)) dut_all (
    .i_clk(clk), .i_reset(reset), .i_value(value), .i_dp(dp), .i_load(load),
    .i_enable(enable), .o_digit_sel(sel_all), .o_seg(seg_all),
    .o_pending(pend_all), .o_frame_tick(ft_all));

  function automatic logic [7:0] exp_seg(int k, logic [15:0] v, logic [3:0] d, bit lz);
    logic [3:0]  n;
    logic [15:0] upper;
    upper = v >> (4 * k);
    n     = upper[3:0];
    if (lz && k > 0 && upper == 16'h0) return {~d[k], 7'h7F};
    return {~d[k], HEX_TBL[n][6:0]};
  endfunction

  task automatic checkOutput(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(logic [15:0] v, logic [3:0] d, logic ld, logic en, logic rst);
    value  = v;
    dp     = d;
    load   = ld;
    enable = en;
    reset  = rst;
    @(negedge clk);
  endtask

  task automatic waitSel(logic [1:0] k);
    int n = 0;
    while (sel_lz !== k && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_sel", 16'(sel_lz), 16'(k));
  endtask

  task automatic waitFrameTick();
    int n = 0;
    while (ft_lz !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_frame_tick", 16'(ft_lz), 16'd1);
  endtask

  task automatic collectFrame();
    for (int i = 0; i < FRAME; i++) begin
      got_lz[sel_lz]   = seg_lz;
      got_all[sel_all] = seg_all;
      @(negedge clk);
    end
  endtask

  task automatic checkFrame(string name, logic [31:0] exp_lz, logic [31:0] exp_all);
    for (int k = 0; k < 4; k++) begin
      checkOutput({name, "_lz"},  16'(got_lz[k]),  16'(exp_lz[8*k +: 8]));
      checkOutput({name, "_all"}, 16'(got_all[k]), 16'(exp_all[8*k +: 8]));
    end
  endtask

  // Model: index and wrap follow directly from the cycle count since reset.
  always @(posedge clk) begin
    if (reset) begin
      m_valid   = 1'b1;
      m_cyc     = 0;
      m_disp    = '0;
      m_dp      = '0;
      m_pv      = '0;
      m_pdp     = '0;
      m_pend    = 1'b0;
      m_ft      = 1'b0;
      m_sel     = 2'd0;
      m_seg_lz  = 8'hFF;
      m_seg_all = 8'hFF;
    end else if (m_valid) begin
      m_wrap = (m_cyc % FRAME) == FRAME - 1;
      m_cyc++;
      m_sel = 2'((m_cyc / DIV) % 4);
      m_ft  = m_wrap;
      if (m_wrap) begin
        if (load) begin
          m_disp = value;
          m_dp   = dp;
        end else if (m_pend) begin
          m_disp = m_pv;
          m_dp   = m_pdp;
        end
        m_pend = 1'b0;
      end else if (load) begin
        m_pv   = value;
        m_pdp  = dp;
        m_pend = 1'b1;
      end
      m_seg_lz  = enable ? exp_seg(int'(m_sel), m_disp, m_dp, 1'b1) : 8'hFF;
      m_seg_all = enable ? exp_seg(int'(m_sel), m_disp, m_dp, 1'b0) : 8'hFF;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("model_sel_lz",   16'(sel_lz),   16'(m_sel));
      checkOutput("model_seg_lz",   16'(seg_lz),   16'(m_seg_lz));
      checkOutput("model_pend_lz",  16'(pend_lz),  16'(m_pend));
      checkOutput("model_ft_lz",    16'(ft_lz),    16'(m_ft));
      checkOutput("model_sel_all",  16'(sel_all),  16'(m_sel));
      checkOutput("model_seg_all",  16'(seg_all),  16'(m_seg_all));
      checkOutput("model_pend_all", 16'(pend_all), 16'(m_pend));
      checkOutput("model_ft_all",   16'(ft_all),   16'(m_ft));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int hold0;
    logic [1:0] sel_start;

    vecs[0] = '{16'h1234, 4'b0100, 32'hF924B099, 32'hF924B099};
    vecs[1] = '{16'h0050, 4'b0000, 32'hFFFF92C0, 32'hC0C092C0};
    vecs[2] = '{16'h0000, 4'b1111, 32'h7F7F7F40, 32'h40404040};
    vecs[3] = '{16'h00F0, 4'b0001, 32'hFFFF8E40, 32'hC0C08E40};
    vecs[4] = '{16'h0809, 4'b1000, 32'h7F80C090, 32'h4080C090};
    vecs[5] = '{16'h7E6B, 4'b0010, 32'hF8860283, 32'hF8860283};

    reset = 1'b1; load = 1'b0; enable = 1'b1; value = '0; dp = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_sel",  16'(sel_lz),  16'd0);
    checkOutput("reset_seg",  16'(seg_lz),  16'hFF);
    checkOutput("reset_pend", 16'(pend_lz), 16'd0);
    checkOutput("reset_ft",   16'(ft_lz),   16'd0);

    // Scan timing: frame period and digit-0 dwell time
    applyStimulus(16'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    waitFrameTick();
    n = 0;
    hold0 = 0;
    do begin
      if (sel_lz == 2'd0) hold0++;
      if (sel_lz == 2'd0) checkOutput("scan_seg_d0", 16'(seg_lz), 16'hC0);
      else                checkOutput("scan_seg_blank", 16'(seg_lz), 16'hFF);
      @(negedge clk);
      n++;
    end while (ft_lz !== 1'b1 && n < 40);
    checkOutput("frame_period", 16'(n), 16'(FRAME));
    checkOutput("sel0_hold", 16'(hold0), 16'(DIV));

    // Table-driven frames: load at index 1, observe the committed frame
    for (int i = 0; i < 6; i++) begin
      waitSel(2'd1);
      applyStimulus(vecs[i].value, vecs[i].dp, 1'b1, 1'b1, 1'b0);
      checkOutput("pend_set", 16'(pend_lz), 16'd1);
      applyStimulus(16'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      waitFrameTick();
      checkOutput("pend_clear", 16'(pend_lz), 16'd0);
      collectFrame();
      checkFrame("vec_frame", vecs[i].lz, vecs[i].all);
    end

    // Load coincident with the wrap edge overrides a pending value
    waitFrameTick();
    applyStimulus(16'h1111, 4'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("coinc_pend", 16'(pend_lz), 16'd1);
    applyStimulus(16'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    repeat (FRAME - 3) @(negedge clk);
    applyStimulus(16'hABCD, 4'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("coinc_ft",   16'(ft_lz),   16'd1);
    checkOutput("coinc_pend0", 16'(pend_lz), 16'd0);
    checkOutput("coinc_seg0", 16'(seg_lz),  16'hA1);
    applyStimulus(16'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    waitFrameTick();
    collectFrame();
    checkFrame("coinc_frame", 32'h8883C6A1, 32'h8883C6A1);

    // Display disabled for 10 cycles mid-frame
    waitSel(2'd1);
    sel_start = sel_lz;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("disable_seg", 16'(seg_lz), 16'hFF);
    end
    checkOutput("disable_scan", 16'(sel_lz != sel_start), 16'd1);
    applyStimulus(16'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("reenable_seg", 16'(seg_lz), 16'(exp_seg(int'(m_sel), 16'hABCD, 4'h0, 1'b1)));

    // Reset while a value is pending at index 2
    waitSel(2'd1);
    applyStimulus(16'h5555, 4'hF, 1'b1, 1'b1, 1'b0);
    applyStimulus(16'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("prereset_pend", 16'(pend_lz), 16'd1);
    waitSel(2'd2);
    applyStimulus(16'h0, 4'h0, 1'b1, 1'b1, 1'b1);
    checkOutput("midreset_sel",  16'(sel_lz),  16'd0);
    checkOutput("midreset_pend", 16'(pend_lz), 16'd0);
    checkOutput("midreset_seg",  16'(seg_lz),  16'hFF);
    applyStimulus(16'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    waitFrameTick();
    collectFrame();
    checkFrame("postreset_frame", 32'hFFFFFFC0, 32'hC0C0C0C0);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(16'($urandom), 4'($urandom),
                    1'($urandom_range(7) == 0),
                    1'($urandom_range(9) != 0),
                    1'($urandom_range(499) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit 7-segment display.
- Directly upstream of the 2-to-4 active-low digit-select decoder:
  - o_digit_sel drives the decoder's 2-bit select input.
  - o_seg drives the shared segment lines (common anode, active-low).
- Holds a 16-bit hex value plus per-digit decimal points in a display register, updated only at frame boundaries so the display never tears.
- Cycles the digit index at a programmable scan rate.

Parameters:
P_SCAN_DIV, 100000, clock cycles per digit slot (≥2); 1 kHz digit rate at 100 MHz
P_BLANK_LZ, 1, 1 = blank leading-zero digits 3..1; 0 = show all digits

Ports:
i_clk  input  1  system clock, rising edge
i_reset  input  1  synchronous, active-high reset
i_value  input  16  hex value; digit k = i_value[4k+3:4k], digit 0 least significant
i_dp  input  4  decimal-point request per digit, active-high; bit k → digit k
i_load  input  1  one-cycle strobe: capture i_value/i_dp for next frame
i_enable  input  1  1 = display on; 0 = all segments off (scan continues)
o_digit_sel  output  2  current digit index, to the 2-to-4 decoder
o_seg  output  8  {dp,g,f,e,d,c,b,a}, active-low
o_pending  output  1  captured value waiting for the frame boundary
o_frame_tick  output  1  one-cycle pulse on the edge where the index wraps 3→0

Behaviour:
- One clock (i_clk); reset synchronous, active-high (i_reset); all outputs registered.
- Reset values:
  - prescaler = 0, index = 0, display reg = 0, dp reg = 0, pending buffer = 0
  - o_pending = 0, o_frame_tick = 0, o_digit_sel = 0, o_seg = 8'hFF.
- Prescaler:
  - Counts 0..P_SCAN_DIV-1 and wraps to 0.
  - tick = (prescaler == P_SCAN_DIV-1).
  - Width = $clog2(P_SCAN_DIV).
- Digit index:
  - Advances 0→1→2→3→0 on tick; holds otherwise.
  - A full frame is 4*P_SCAN_DIV cycles.
- Commit: occurs on the tick edge where the index goes 3→0.
  - Display reg ← i_value if i_load is high that cycle, else pending buffer. Same rule for the dp reg.
  - Only happens when o_pending=1 or i_load=1; otherwise the display reg holds.
  - o_pending ← 0.
- Capture (i_load=1, not a commit edge):
  - Pending buffer ← {i_value, i_dp}; o_pending ← 1.
  - Repeated loads before a commit overwrite the buffer; the last one wins.
- o_frame_tick: 1 for exactly the cycle following each commit edge (every 3→0 wrap, whether or not a value was committed).
- Segment output:
  - o_seg and o_digit_sel update on the same edge; no one-cycle lag (no ghosting).
  - o_seg is computed from the next index and the next display/dp reg values, including a commit on that edge.
- Hex encoding (dp bit = 1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Decimal point: o_seg[7] = ~dp_reg[index].
- Leading-zero blanking (P_BLANK_LZ=1):
  - Digit k (k=1..3) is blanked when nibbles k..3 are all zero; blanked means o_seg[6:0] = 7'h7F.
  - The dp bit still follows dp_reg.
  - Digit 0 is never blanked.
- i_enable=0:
  - o_seg = 8'hFF on the next edge.
  - Prescaler, index, capture and commit are unaffected.
  - Re-enable restores segments on the next edge.
- Reset mid-frame: all state returns to reset values on that edge, and any pending value is discarded.
- Reset is dominant over i_load and over tick.

Test Plan:
- Scan timing (P_SCAN_DIV=4, i_enable=1, no load) after reset:
  - o_digit_sel goes 0,1,2,3,0 with each value held 4 cycles.
  - o_frame_tick pulses once every 16 cycles.
  - o_seg = C0 while digit 0 is selected and FF on digits 1..3 (blanked).
- Load 16'h1234, i_dp=4'b0100, at index 1:
  - o_pending=1 until the 3→0 wrap, and the old value is displayed until then.
  - After the wrap: digit0=99, digit1=B0, digit2=24 (dp on), digit3=F9; o_pending=0.
- Load 16'h0050 with P_BLANK_LZ=1:
  - Digits 3,2 = FF, digit1 = 92, digit0 = C0.
  - Same value with P_BLANK_LZ=0: digits 3,2 = C0.
- i_load coincident with the commit edge, carrying 16'hABCD while a pending 16'h1111 exists:
  - Display shows ABCD: digit0=A1, digit1=C6, digit2=83, digit3=88.
  - o_pending=0.
- i_enable=0 for 10 cycles mid-frame:
  - o_seg=FF throughout while o_digit_sel keeps scanning.
  - On re-enable, the correct segments appear on the next edge.
- i_reset pulsed while o_pending=1 at index 2:
  - Next cycle: index 0, o_pending=0, o_seg=FF.
  - Subsequent frames show 0: C0 on digit 0, FF on digits 1..3.
